wb_regfile_hilo: RTL and testbench
==================================

Name: wb_regfile_hilo

Overview:
Receiving end of the write-back bus produced by the WB stage. Holds the 32x32 general-purpose register file and the HI/LO special registers. Commits GPR, HI and LO writes carried on the wide write-back bus at the clock edge. Serves ID with two combinational GPR read ports and one HI/LO read port, each with same-cycle write bypass.

Parameters:
WB_TO_RF_WD, 38, width of the base GPR write field {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
BUS_WD, WB_TO_RF_WD+64+1+2 (=105), full write-back bus width
RESET_VAL, 32'h0, reset value of every GPR, HI and LO

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
wb_to_rf_bus  in  BUS_WD  {lo_wen, hi_wen, hilo_from_muldiv, muldiv_result[63:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}, MSB first
raddr1  in  5  GPR read port 1 address
rdata1  out  32  GPR read port 1 data
raddr2  in  5  GPR read port 2 address
rdata2  out  32  GPR read port 2 data
hi_rdata  out  32  current HI value, bypassed
lo_rdata  out  32  current LO value, bypassed
wr_count  out  32  count of committed GPR writes, excluding r0 and discarded writes

Behaviour:
- Reset (rst=0, async): GPR[1..31], HI and LO go to RESET_VAL immediately; wr_count goes to 0. While rst=0, writes are ignored and read outputs show reset state.
- No pipeline register inside. The bus is the already-registered WB stage output and is sampled every posedge. There is no stall input: WB zeroes the bus on bubbles, and an all-zero bus is a no-op.
- GPR write: at posedge, if rf_we=1 and rf_waddr!=0, then GPR[rf_waddr] <= rf_wdata and wr_count increments by 1 (wraps 32'hFFFFFFFF -> 0).
- rf_we=1 with rf_waddr=0: write discarded, wr_count unchanged.
- r0 is hard-wired. rdataN = 0 whenever raddrN=0, regardless of any write.
- GPR read, combinational. If rf_we=1 and rf_waddr==raddrN!=0, then rdataN = rf_wdata (same-cycle bypass). Otherwise rdataN = GPR[raddrN]. Both ports are independent, and both may hit the bypass at once.
- HI/LO write source select:
  - hilo_from_muldiv=1: hi_wen writes HI <= muldiv_result[63:32]; lo_wen writes LO <= muldiv_result[31:0].
  - hilo_from_muldiv=0 (mthi/mtlo): hi_wen writes HI <= rf_wdata; lo_wen writes LO <= rf_wdata.
  - hi_wen and lo_wen act independently; both may be 1 in one cycle.
- hilo_from_muldiv=1 with hi_wen=lo_wen=0: no HI/LO change.
- HI/LO bypass: hi_rdata = the value HI will take at the next edge if hi_wen=1, else HI. lo_rdata follows the same rule.
- Simultaneous events: one bus beat may write a GPR and HI/LO together; all updates commit on the same edge.
- Reset asserted mid-operation: state clears asynchronously. The in-flight beat at that edge is lost.
- Deassertion of reset is synchronised upstream; the block has no reset synchroniser.

Test Plan:
1. Reset, then raddr1=5, raddr2=0 -> rdata1=0, rdata2=0, hi_rdata=lo_rdata=0, wr_count=0.
2. Bus rf_we=1, waddr=5, wdata=32'hDEADBEEF with raddr1=5 in the same cycle -> rdata1=DEADBEEF combinationally. After the edge, GPR[5]=DEADBEEF and wr_count=1.
3. rf_we=1, waddr=0, wdata=32'h1234 -> rdata at raddr=0 stays 0, both before and after the edge; wr_count unchanged.
4. hilo_from_muldiv=1, hi_wen=lo_wen=1, muldiv_result=64'h0000000A_00000003 -> hi_rdata=A and lo_rdata=3 in the same cycle, latched after the edge. The next beat with an all-zero bus holds HI=A, LO=3.
5. hilo_from_muldiv=0, hi_wen=1, lo_wen=0, rf_we=1, waddr=7, wdata=32'h55 -> HI=55, LO unchanged, GPR[7]=55; all three commit on one edge.
6. rst pulsed low for half a cycle mid-stream after writes to r1..r31 -> all reads return 0 immediately (async), wr_count=0, and the beat at that edge is not committed.

Source files
------------

// File: rtl/wb_regfile_hilo.sv
// Write-back receiving register file: 32x32 GPRs plus HI/LO, with combinational
// read ports that bypass the beat currently on the write-back bus.
module wb_regfile_hilo #(
    parameter int          WB_TO_RF_WD = 38,
    parameter int          BUS_WD      = WB_TO_RF_WD + 64 + 1 + 2,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]        raddr1,
    output logic [31:0]       rdata1,
    input  logic [4:0]        raddr2,
    output logic [31:0]       rdata2,
    output logic [31:0]       hi_rdata,
    output logic [31:0]       lo_rdata,
    output logic [31:0]       wr_count
);

    logic        lo_wen;
    logic        hi_wen;
    logic        hilo_from_muldiv;
    logic [63:0] muldiv_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign rf_wdata         = wb_to_rf_bus[31:0];
    assign rf_waddr         = wb_to_rf_bus[36:32];
    assign rf_we            = wb_to_rf_bus[WB_TO_RF_WD-1];
    assign muldiv_result    = wb_to_rf_bus[WB_TO_RF_WD +: 64];
    assign hilo_from_muldiv = wb_to_rf_bus[WB_TO_RF_WD+64];
    assign hi_wen           = wb_to_rf_bus[WB_TO_RF_WD+65];
    assign lo_wen           = wb_to_rf_bus[WB_TO_RF_WD+66];

    logic [31:0] gpr [32];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_src;
    logic [31:0] lo_src;
    logic        gpr_commit;
    logic        hi_commit;
    logic        lo_commit;

    // Nothing is committed or bypassed while reset is held.
    assign gpr_commit = rst && rf_we && (rf_waddr != 5'd0);
    assign hi_commit  = rst && hi_wen;
    assign lo_commit  = rst && lo_wen;
    assign hi_src     = hilo_from_muldiv ? muldiv_result[63:32] : rf_wdata;
    assign lo_src     = hilo_from_muldiv ? muldiv_result[31:0]  : rf_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= RESET_VAL;
            end
            hi_q     <= RESET_VAL;
            lo_q     <= RESET_VAL;
            wr_count <= 32'd0;
        end else begin
            if (gpr_commit) begin
                gpr[rf_waddr] <= rf_wdata;
                wr_count      <= wr_count + 32'd1;
            end
            if (hi_commit) begin
                hi_q <= hi_src;
            end
            if (lo_commit) begin
                lo_q <= lo_src;
            end
        end
    end

    always_comb begin
        rdata1 = gpr[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end else if (gpr_commit && (rf_waddr == raddr1)) begin
            rdata1 = rf_wdata;
        end
    end

    always_comb begin
        rdata2 = gpr[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end else if (gpr_commit && (rf_waddr == raddr2)) begin
            rdata2 = rf_wdata;
        end
    end

    assign hi_rdata = hi_commit ? hi_src : hi_q;
    assign lo_rdata = lo_commit ? lo_src : lo_q;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Directed bench for wb_regfile_hilo: bypass, commit, r0, HI/LO sources and async reset.
module tb_wb_regfile_hilo;

    logic         clk;
    logic         rst;
    logic [104:0] wb_to_rf_bus;
    logic [4:0]   raddr1;
    logic [31:0]  rdata1;
    logic [4:0]   raddr2;
    logic [31:0]  rdata2;
    logic [31:0]  hi_rdata;
    logic [31:0]  lo_rdata;
    logic [31:0]  wr_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [104:0] mk_bus(input logic lo_wen, input logic hi_wen,
                                            input logic from_md, input logic [63:0] md,
                                            input logic we, input logic [4:0] waddr,
                                            input logic [31:0] wdata);
        return {lo_wen, hi_wen, from_md, md, we, waddr, wdata};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Finish the current beat: let the edge commit, then idle the bus.
    task automatic commit_beat();
        @(posedge clk);
        #1;
        wb_to_rf_bus = '0;
    endtask

    initial begin
        rst          = 1'b0;
        wb_to_rf_bus = '0;
        raddr1       = 5'd5;
        raddr2       = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rdata1", rdata1, 32'h0);
        check_val("rst_rdata2", rdata2, 32'h0);
        check_val("rst_hi", hi_rdata, 32'h0);
        check_val("rst_lo", lo_rdata, 32'h0);
        check_val("rst_cnt", wr_count, 32'h0);

        // Writes while reset is held are ignored and not bypassed.
        wb_to_rf_bus = mk_bus(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 5'd5, 32'h0BAD_0BAD);
        #1;
        check_val("rst_nobyp_gpr", rdata1, 32'h0);
        check_val("rst_nobyp_hi", hi_rdata, 32'h0);
        commit_beat();
        check_val("rst_nowrite", rdata1, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        // GPR bypass and commit.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        raddr1 = 5'd5;
        #1;
        check_val("byp_r5", rdata1, 32'hDEAD_BEEF);
        check_val("cnt_before", wr_count, 32'd0);
        commit_beat();
        check_val("r5_latched", rdata1, 32'hDEAD_BEEF);
        check_val("cnt_1", wr_count, 32'd1);

        // r0 write is discarded.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 5'd0, 32'h0000_1234);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        check_val("r0_byp1", rdata1, 32'h0);
        check_val("r0_byp2", rdata2, 32'h0);
        commit_beat();
        check_val("r0_after", rdata1, 32'h0);
        check_val("cnt_r0", wr_count, 32'd1);

        // Both ports hit the bypass together.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 5'd9, 32'h0000_0099);
        raddr1 = 5'd9;
        raddr2 = 5'd9;
        #1;
        check_val("dual_byp1", rdata1, 32'h99);
        check_val("dual_byp2", rdata2, 32'h99);
        commit_beat();
        raddr2 = 5'd5;
        #1;
        check_val("r9_latched", rdata1, 32'h99);
        check_val("r5_kept", rdata2, 32'hDEAD_BEEF);
        check_val("cnt_2", wr_count, 32'd2);

        // HI/LO from mul/div result.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b1, 1'b1, 1'b1, 64'h0000_000A_0000_0003, 1'b0, 5'd0, 32'h0);
        #1;
        check_val("md_hi_byp", hi_rdata, 32'hA);
        check_val("md_lo_byp", lo_rdata, 32'h3);
        commit_beat();
        check_val("md_hi_q", hi_rdata, 32'hA);
        check_val("md_lo_q", lo_rdata, 32'h3);
        @(posedge clk);
        #1;
        check_val("md_hi_hold", hi_rdata, 32'hA);
        check_val("md_lo_hold", lo_rdata, 32'h3);

        // mthi plus GPR write on one beat; muldiv field carries a decoy.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b1, 1'b0, 64'hFFFF_0000_EEEE_1111, 1'b1, 5'd7, 32'h0000_0055);
        raddr1 = 5'd7;
        #1;
        check_val("mthi_byp", hi_rdata, 32'h55);
        check_val("mthi_lo_byp", lo_rdata, 32'h3);
        commit_beat();
        check_val("mthi_hi", hi_rdata, 32'h55);
        check_val("mthi_lo", lo_rdata, 32'h3);
        check_val("mthi_r7", rdata1, 32'h55);
        check_val("cnt_3", wr_count, 32'd3);

        // LO-only from mul/div.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b1, 1'b0, 1'b1, 64'h1111_1111_2222_2222, 1'b0, 5'd0, 32'h0);
        commit_beat();
        check_val("lo_only_lo", lo_rdata, 32'h2222_2222);
        check_val("lo_only_hi", hi_rdata, 32'h55);

        // from_muldiv with no enables changes nothing.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b1, 64'h3333_3333_4444_4444, 1'b0, 5'd0, 32'h0);
        #1;
        check_val("noen_hi_byp", hi_rdata, 32'h55);
        commit_beat();
        check_val("noen_hi", hi_rdata, 32'h55);
        check_val("noen_lo", lo_rdata, 32'h2222_2222);

        // Fill r1..r31.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 5'(i), 32'h0101_0101 * i);
            commit_beat();
        end
        raddr1 = 5'd1;
        raddr2 = 5'd31;
        #1;
        check_val("fill_r1", rdata1, 32'h0101_0101);
        check_val("fill_r31", rdata2, 32'h1F1F_1F1F);
        check_val("cnt_34", wr_count, 32'd34);

        // Async reset pulse mid-stream; the beat at the reset edge is lost.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 5'd3, 32'h0000_CAFE);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_r1", rdata1, 32'h0);
        check_val("arst_r31", rdata2, 32'h0);
        check_val("arst_hi", hi_rdata, 32'h0);
        check_val("arst_lo", lo_rdata, 32'h0);
        check_val("arst_cnt", wr_count, 32'h0);
        @(negedge clk);
        rst          = 1'b1;
        wb_to_rf_bus = '0;
        raddr1       = 5'd3;
        #1;
        check_val("lost_r3", rdata1, 32'h0);
        check_val("lost_hi", hi_rdata, 32'h0);
        check_val("lost_cnt", wr_count, 32'h0);

        // Block is usable again after reset.
        @(negedge clk);
        wb_to_rf_bus = mk_bus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 5'd4, 32'h0000_0044);
        raddr1 = 5'd4;
        commit_beat();
        check_val("post_r4", rdata1, 32'h44);
        check_val("post_cnt", wr_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
